// File: rtl/calc_seq_ctrl_pkg.sv
// Shared types and constants for the BCD calculator sequencer.
// Provides the FSM state enum, operator enum, digit geometry and a BCD
// digit validity helper.
package calc_pkg;

  localparam int unsigned NDIG   = 4;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned WORD_W = NDIG * DIG_W;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned K_W    = 2;

  localparam logic [DIG_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_OP_B    = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_CALC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_valid(input logic [DIG_W-1:0] d);
    return (d <= BCD_NINE);
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Keypad / display bus of the calculator sequencer.
// master: keypad side (drives d_in and strobes, observes display/status).
// slave : controller side (observes keypad, drives display/status).
interface calc_seq_ctrl_if;
  logic [3:0] d_in;
  logic       ent;
  logic       pls;
  logic       mns;
  logic       eq;
  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic       q4;
  logic       qmin;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output d_in, ent, pls, mns, eq,
    input  q0, q1, q2, q3, q4, qmin, busy, done, err
  );

  modport slave (
    input  d_in, ent, pls, mns, eq,
    output q0, q1, q2, q3, q4, qmin, busy, done, err
  );
endinterface

// File: rtl/calc_seq_ctrl_bcd_digit_add.sv
// Single-digit BCD adder, time-shared across the four CALC cycles.
// Ports: i_a, i_b (BCD digits, i_b may be a nines complement), i_cin;
//        o_sum_c (corrected BCD digit), o_cout_c (decimal carry).
module bcd_digit_add
  import calc_pkg::*;
(
  input  logic [DIG_W-1:0] i_a,
  input  logic [DIG_W-1:0] i_b,
  input  logic             i_cin,
  output logic [DIG_W-1:0] o_sum_c,
  output logic             o_cout_c
);

  logic [DIG_W:0] w_raw;
  logic [DIG_W:0] w_adj;
  logic           w_fix;

  // Binary sum of two digits plus carry tops out at 19, so 5 bits suffice.
  assign w_raw    = 5'(i_a) + 5'(i_b) + 5'(i_cin);
  assign w_fix    = (w_raw > 5'(BCD_NINE));
  assign w_adj    = w_raw + 5'd6;
  assign o_sum_c  = w_fix ? w_adj[DIG_W-1:0] : w_raw[DIG_W-1:0];
  assign o_cout_c = w_fix;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencer for a 4-digit BCD calculator: keypad entry of A and B,
// operator latch, digit-serial add/subtract over four clocks, and the
// signed 4.5-digit display.
// Ports: clk, clr (async active-high reset), bus (calc_seq_ctrl_if.slave:
//        d_in/ent/pls/mns/eq in; q0..q3/q4/qmin/busy/done/err out).
// Option: CALC_CHAIN_EN lets pls/mns in SHOW chain on the last result.
module calc_seq_ctrl
  import calc_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  calc_seq_ctrl_if.slave bus
);

  state_t              r_state, n_state;
  op_t                 r_op, n_op;
  logic [WORD_W-1:0]   r_a, n_a;
  logic [WORD_W-1:0]   r_b, n_b;
  logic [CNT_W-1:0]    r_cnt_a, n_cnt_a;
  logic [CNT_W-1:0]    r_cnt_b, n_cnt_b;
  logic [WORD_W-1:0]   r_big, n_big;
  logic [WORD_W-1:0]   r_small, n_small;
  logic [WORD_W-1:0]   r_res, n_res;
  logic                r_carry, n_carry;
  logic                r_neg, n_neg;
  logic [K_W-1:0]      r_k, n_k;
  logic [WORD_W-1:0]   r_disp, n_disp;
  logic                r_q4, n_q4;
  logic                r_qmin, n_qmin;
  logic                r_busy, n_busy;
  logic                r_done, n_done;
  logic                r_err, n_err;

  logic [3:0]          w_strb;
  logic                w_multi;
  logic                w_dig_ok;
  logic [DIG_W-1:0]    w_big_dig;
  logic [DIG_W-1:0]    w_small_dig;
  logic [DIG_W-1:0]    w_b_in;
  logic [DIG_W-1:0]    w_sum;
  logic                w_cout;

  assign w_strb   = {bus.ent, bus.pls, bus.mns, bus.eq};
  assign w_multi  = ($countones(w_strb) > 1);
  assign w_dig_ok = bcd_valid(bus.d_in);

  // Current digit pair; subtraction feeds the nines complement of the smaller operand.
  assign w_big_dig   = r_big[{r_k, 2'b00} +: DIG_W];
  assign w_small_dig = r_small[{r_k, 2'b00} +: DIG_W];
  assign w_b_in      = (r_op == OP_SUB) ? (BCD_NINE - w_small_dig) : w_small_dig;

  bcd_digit_add u_add (
    .i_a      (w_big_dig),
    .i_b      (w_b_in),
    .i_cin    (r_carry),
    .o_sum_c  (w_sum),
    .o_cout_c (w_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_ENTER_A;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_big   <= '0;
      r_small <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
      r_k     <= '0;
      r_disp  <= '0;
      r_q4    <= 1'b0;
      r_qmin  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= n_state;
      r_op    <= n_op;
      r_a     <= n_a;
      r_b     <= n_b;
      r_cnt_a <= n_cnt_a;
      r_cnt_b <= n_cnt_b;
      r_big   <= n_big;
      r_small <= n_small;
      r_res   <= n_res;
      r_carry <= n_carry;
      r_neg   <= n_neg;
      r_k     <= n_k;
      r_disp  <= n_disp;
      r_q4    <= n_q4;
      r_qmin  <= n_qmin;
      r_busy  <= n_busy;
      r_done  <= n_done;
      r_err   <= n_err;
    end
  end

  // Next-state and output logic.
  always_comb begin
    n_state = r_state;
    n_op    = r_op;
    n_a     = r_a;
    n_b     = r_b;
    n_cnt_a = r_cnt_a;
    n_cnt_b = r_cnt_b;
    n_big   = r_big;
    n_small = r_small;
    n_res   = r_res;
    n_carry = r_carry;
    n_neg   = r_neg;
    n_k     = r_k;
    n_disp  = r_disp;
    n_q4    = r_q4;
    n_qmin  = r_qmin;
    n_busy  = r_busy;
    n_done  = 1'b0;
    n_err   = 1'b0;

    case (r_state)
      ST_ENTER_A: begin
        if (w_multi) begin
          n_err = 1'b1;
        end else if (bus.ent) begin
          if (!w_dig_ok || (r_cnt_a == CNT_W'(NDIG))) begin
            n_err = 1'b1;
          end else begin
            n_a     = {r_a[WORD_W-DIG_W-1:0], bus.d_in};
            n_cnt_a = r_cnt_a + CNT_W'(1);
            n_disp  = n_a;
          end
        end else if (bus.pls || bus.mns) begin
          n_op    = bus.mns ? OP_SUB : OP_ADD;
          n_b     = '0;
          n_cnt_b = '0;
          n_disp  = '0;
          n_state = ST_OP_B;
        end else if (bus.eq) begin
          n_err = 1'b1;
        end
      end

      ST_OP_B, ST_ENTER_B: begin
        if (w_multi || bus.pls || bus.mns) begin
          n_err = 1'b1;
        end else if (bus.ent) begin
          if (!w_dig_ok || (r_cnt_b == CNT_W'(NDIG))) begin
            n_err = 1'b1;
          end else begin
            n_b     = {r_b[WORD_W-DIG_W-1:0], bus.d_in};
            n_cnt_b = r_cnt_b + CNT_W'(1);
            n_disp  = n_b;
            n_state = ST_ENTER_B;
          end
        end else if (bus.eq) begin
          // Packed BCD orders the same as binary, so a plain compare picks the larger.
          if ((r_op == OP_SUB) && (r_b > r_a)) begin
            n_big   = r_b;
            n_small = r_a;
            n_neg   = 1'b1;
          end else begin
            n_big   = r_a;
            n_small = r_b;
            n_neg   = 1'b0;
          end
          n_carry = (r_op == OP_SUB);
          n_res   = '0;
          n_k     = '0;
          n_busy  = 1'b1;
          n_state = ST_CALC;
        end
      end

      ST_CALC: begin
        // Strobes are deliberately ignored here; one digit per clock.
        n_res[{r_k, 2'b00} +: DIG_W] = w_sum;
        n_carry = w_cout;
        n_k     = r_k + K_W'(1);
        if (r_k == K_W'(NDIG - 1)) begin
          n_disp  = n_res;
          n_q4    = (r_op == OP_ADD) ? w_cout : 1'b0;
          n_qmin  = (r_op == OP_SUB) ? r_neg : 1'b0;
          n_busy  = 1'b0;
          n_done  = 1'b1;
          n_state = ST_SHOW;
        end
      end

      ST_SHOW: begin
        if (w_multi) begin
          n_err = 1'b1;
        end else if (bus.ent) begin
          if (!w_dig_ok) begin
            n_err = 1'b1;
          end else begin
            n_a     = {{(WORD_W-DIG_W){1'b0}}, bus.d_in};
            n_cnt_a = CNT_W'(1);
            n_b     = '0;
            n_cnt_b = '0;
            n_op    = OP_ADD;
            n_neg   = 1'b0;
            n_q4    = 1'b0;
            n_qmin  = 1'b0;
            n_disp  = n_a;
            n_state = ST_ENTER_A;
          end
        end else if (bus.pls || bus.mns) begin
`ifdef CALC_CHAIN_EN
          // Only an in-range, non-negative result can become the next A.
          if (r_q4 || r_qmin) begin
            n_err = 1'b1;
          end else begin
            n_a     = r_res;
            n_cnt_a = CNT_W'(NDIG);
            n_op    = bus.mns ? OP_SUB : OP_ADD;
            n_b     = '0;
            n_cnt_b = '0;
            n_neg   = 1'b0;
            n_disp  = '0;
            n_state = ST_OP_B;
          end
`else
          n_err = 1'b1;
`endif
        end
      end

      default: n_state = ST_ENTER_A;
    endcase
  end

  assign bus.q0   = r_disp[3:0];
  assign bus.q1   = r_disp[7:4];
  assign bus.q2   = r_disp[11:8];
  assign bus.q3   = r_disp[15:12];
  assign bus.q4   = r_q4;
  assign bus.qmin = r_qmin;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with a result scoreboard.
module tb_calc_seq_ctrl;

  typedef struct packed {
    logic [15:0] disp;
    logic        q4;
    logic        qmin;
  } exp_t;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  calc_seq_ctrl_if bus ();

  calc_seq_ctrl u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] disp();
    return {bus.q3, bus.q2, bus.q1, bus.q0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.ent = 1'b1; bus.d_in = d;
    tick();
    bus.ent = 1'b0; bus.d_in = 4'd0;
  endtask

  task automatic opk(input bit sub);
    bus.pls = !sub; bus.mns = sub;
    tick();
    bus.pls = 1'b0; bus.mns = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_disp"}, 32'(disp()), 32'h0);
    chk({tag, "_flags"}, {27'd0, bus.q4, bus.qmin, bus.busy, bus.done, bus.err}, 32'h0);
  endtask

  // Issue eq, then wait (bounded) for done and compare against the scoreboard.
  task automatic do_eq(input bit inject);
    exp_t e;
    bit   got;
    got = 1'b0;
    bus.eq = 1'b1;
    tick();
    bus.eq = 1'b0;
    chk("busy_start", 32'(bus.busy), 32'd1);
    for (int c = 1; c <= 8 && !got; c++) begin
      if (inject && c == 1) begin bus.ent = 1'b1; bus.d_in = 4'd3; end
      if (inject && c == 2) bus.eq = 1'b1;
      tick();
      bus.ent = 1'b0; bus.eq = 1'b0; bus.d_in = 4'd0;
      chk("no_err_calc", 32'(bus.err), 32'd0);
      if (bus.done) begin
        got = 1'b1;
        chk("latency", 32'(c), 32'd4);
        chk("busy_end", 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(disp()), 32'(e.disp));
          chk("q4", 32'(bus.q4), 32'(e.q4));
          chk("qmin", 32'(bus.qmin), 32'(e.qmin));
        end
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    tick();
    chk("done_single", 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.d_in = 4'd0; bus.ent = 1'b0; bus.pls = 1'b0; bus.mns = 1'b0; bus.eq = 1'b0;
    clr = 1'b1;
    #1;
    chk_zero("reset");
    tick();
    clr = 1'b0;
    tick();
    chk_zero("reset_idle");

    // 1234 + 8766 = 10000
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("disp_a", 32'(disp()), 32'h1234);
    opk(1'b0);
    chk("disp_opb", 32'(disp()), 32'h0);
    key(4'd8); key(4'd7); key(4'd6); key(4'd6);
    chk("disp_b", 32'(disp()), 32'h8766);
    sb.push_back('{disp: 16'h0000, q4: 1'b1, qmin: 1'b0});
    do_eq(1'b0);

    // 250 - 1000 = -750 (new entry from SHOW)
    key(4'd2);
    chk("show_ent", 32'(disp()), 32'h0002);
    chk("show_ent_q4", 32'(bus.q4), 32'd0);
    key(4'd5); key(4'd0);
    opk(1'b1);
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    sb.push_back('{disp: 16'h0750, q4: 1'b0, qmin: 1'b1});
    do_eq(1'b0);

    // 5000 - 5000 = 0
    key(4'd5); key(4'd0); key(4'd0); key(4'd0);
    opk(1'b1);
    key(4'd5); key(4'd0); key(4'd0); key(4'd0);
    sb.push_back('{disp: 16'h0000, q4: 1'b0, qmin: 1'b0});
    do_eq(1'b0);

    // Rejections
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    key(4'd5);
    chk("err_5th", 32'(bus.err), 32'd1);
    chk("disp_5th", 32'(disp()), 32'h1234);
    tick();
    chk("err_clear", 32'(bus.err), 32'd0);
    key(4'hA);
    chk("err_hex", 32'(bus.err), 32'd1);
    chk("disp_hex", 32'(disp()), 32'h1234);
    bus.eq = 1'b1; tick(); bus.eq = 1'b0;
    chk("err_eq_a", 32'(bus.err), 32'd1);
    chk("busy_eq_a", 32'(bus.busy), 32'd0);
    bus.ent = 1'b1; bus.pls = 1'b1; bus.d_in = 4'd7;
    tick();
    bus.ent = 1'b0; bus.pls = 1'b0; bus.d_in = 4'd0;
    chk("err_multi", 32'(bus.err), 32'd1);
    chk("disp_multi", 32'(disp()), 32'h1234);

    // Busy masking: 1234 + 1111 = 2345 with strobes during CALC
    opk(1'b0);
    chk("err_op_ok", 32'(bus.err), 32'd0);
    key(4'd1); key(4'd1); key(4'd1); key(4'd1);
    sb.push_back('{disp: 16'h2345, q4: 1'b0, qmin: 1'b0});
    do_eq(1'b1);

    // Reset in the second CALC cycle
    key(4'd9); opk(1'b0); key(4'd1);
    bus.eq = 1'b1; tick(); bus.eq = 1'b0;
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    clr = 1'b1;
    #1;
    chk_zero("mid_clr");
    tick();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_done_after_clr", 32'(bus.done), 32'd0);
    end
    key(4'd7);
    chk("enter_a_after_clr", 32'(disp()), 32'h0007);

    // 9999 - 0001 = 9998, then chain + 2
    clr = 1'b1; tick(); clr = 1'b0; tick();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    opk(1'b1);
    key(4'd1);
    sb.push_back('{disp: 16'h9998, q4: 1'b0, qmin: 1'b0});
    do_eq(1'b0);
    opk(1'b0);
`ifdef CALC_CHAIN_EN
    chk("chain_err", 32'(bus.err), 32'd0);
    chk("chain_disp", 32'(disp()), 32'h0);
    key(4'd2);
    sb.push_back('{disp: 16'h0000, q4: 1'b1, qmin: 1'b0});
    do_eq(1'b0);
`else
    chk("chain_err", 32'(bus.err), 32'd1);
    chk("chain_disp", 32'(disp()), 32'h9998);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Clocked controller for the 4-digit BCD calculator. It sequences keypad entry into operand registers A and B, latches the operator, and runs a digit-serial add or subtract on one shared 1-digit BCD adder over four clocks. It drives the 4½-digit signed display. It replaces the level-sensitive, fully parallel datapath control with a synchronous FSM that uses a busy/done handshake.

## Interface
- Parameters: none. Digit count is fixed at 4 by the package constant `NDIG`.
- `clk` in 1: system clock; all state changes on the rising edge.
- `clr` in 1: asynchronous, active-high reset; clears all state and outputs.
- `d_in` in 4: BCD digit; valid range 0–9.
- `ent` in 1: one-cycle strobe; `d_in` is valid.
- `pls` in 1: one-cycle strobe; operator is add.
- `mns` in 1: one-cycle strobe; operator is subtract.
- `eq` in 1: one-cycle strobe; start the calculation.
- `q0`..`q3` out 4 each: display digits, LSD to MSD.
- `q4` out 1: result ≥ 10000 (add carry-out).
- `qmin` out 1: result is negative.
- `busy` out 1: high while in CALC.
- `done` out 1: one-cycle pulse when the result is loaded.
- `err` out 1: one-cycle pulse on a rejected input.

## Operation
- States and what each displays:
  - ENTER_A: display shows A.
  - OP_B: display shows 0.
  - ENTER_B: display shows B.
  - CALC: display holds B.
  - SHOW: display shows the result.
- Reset state is ENTER_A. On reset, A, B, the digit counters, the operator and all outputs are 0.
- Accepting a digit (`ent` with `d_in` ≤ 9):
  - In ENTER_A, A ← {A[11:0], d_in}.
  - In OP_B or ENTER_B, B ← {B[11:0], d_in}, then go to ENTER_B.
  - Each operand has a digit counter that saturates at 4.
- Rejected inputs: each pulses `err` and changes no state.
  - A 5th digit.
  - `d_in` > 9.
  - `pls`/`mns` outside ENTER_A (and outside SHOW when `CALC_CHAIN_EN` is defined).
  - `eq` in ENTER_A.
  - More than one of `ent`/`pls`/`mns`/`eq` high in the same cycle.
- `pls`/`mns` in ENTER_A: latch the operator, clear B, go to OP_B.
- `eq` in OP_B or ENTER_B: go to CALC. An empty B counts as 0.
- Subtract setup on the `eq` edge:
  - If B > A (plain 16-bit compare, which is valid for packed BCD), swap the operands and latch neg = 1.
  - Otherwise neg = 0.
  - The initial carry is 1.
- CALC processes one digit per clock, k = 0..3, LSD first:
  - Add: r_k = a_k + b_k + c.
  - Subtract: r_k = big_k + (9 − small_k) + c.
  - Any digit sum > 9 is corrected by +6, carry = 1.
- End of CALC:
  - Add: `q4` = final carry, `qmin` = 0.
  - Subtract: final carry is discarded, `qmin` = neg, `q4` = 0.
- In SHOW, `ent` with a valid digit clears A, B, the operator and the flags, loads A = d_in, and goes to ENTER_A.
- All strobes except `clr` are ignored while `busy` is high. They do not set `err`.
- `q4` and `qmin` are 0 in every state except SHOW.

## Timing
- Strobes are sampled on the rising edge of `clk`.
- Let `eq` be sampled at edge n:
  - `busy` = 1 from edge n through edge n+4.
  - Digit k is written at edge n+k+1.
  - At edge n+4: state = SHOW, outputs show the result, `done` = 1 for one cycle.
- Latency from `eq` to result is 4 clocks.
- `err` is high for the single cycle after the offending edge.
- Display updates on the same edge that accepts a digit.
- `clr` takes effect immediately, without waiting for an edge, including mid-CALC. The partial result is discarded and `done` does not pulse.

## Configuration
- Macro: `CALC_CHAIN_EN`.
- Defined: `pls`/`mns` in SHOW start a chained calculation.
  - Condition: `q4` = 0 and `qmin` = 0.
  - A ← result, operator latched, go to OP_B.
  - If `q4` or `qmin` is set, pulse `err` and stay in SHOW.
- Not defined: `pls`/`mns` in SHOW are rejected with `err`.

## Structure
- Package `calc_pkg`:
  - State enum.
  - Operator enum (OP_ADD, OP_SUB).
  - `NDIG` = 4.
  - `BCD_NINE` = 4'd9.
  - BCD-validity helper function.
- One sub-module, `bcd_digit_add`: combinational adder taking 4-bit a, 4-bit b and cin, producing a 4-bit BCD sum and cout. It is instantiated once and time-shared across the four CALC cycles.

## Test plan
- Overflow add: `clr`; enter 1,2,3,4; `pls`; enter 8,7,6,6; `eq` → 4 clocks later q3..q0 = 0,0,0,0, `q4` = 1, `qmin` = 0, `done` pulses once.
- Negative subtract: enter 2,5,0; `mns`; enter 1,0,0,0; `eq` → 0,7,5,0 with `qmin` = 1. Equal operands 5000 − 5000 → 0000 with `qmin` = 0.
- Rejected entries:
  - Enter 1,2,3,4,5 → A = 1234, `err` pulses on the 5th `ent`.
  - `d_in` = 4'hA → `err`, A unchanged.
  - `ent` and `pls` in the same cycle → `err`, no change.
- Reset mid-CALC: assert `clr` in the 2nd CALC cycle → all outputs 0 immediately, `busy` = 0, state ENTER_A, no `done`.
- Busy masking: pulse `ent` and `eq` during CALC → ignored, no `err`, result correct.
- With `CALC_CHAIN_EN`:
  - 9999 − 0001 = 9998; then `pls`, enter 2, `eq` → 0000 with `q4` = 1.
  - Without the macro, the same `pls` pulses `err`.
